// File: rtl/byte_mem_if.sv
// Bus bundle for one byte_mem bank: write/read request from the master, read data and busy back.
interface byte_mem_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) ();
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output wen,
    output addr,
    output wdata,
    input  rdata,
    input  busy
  );

  modport slave (
    input  wen,
    input  addr,
    input  wdata,
    output rdata,
    output busy
  );
endinterface

// File: rtl/byte_mem.sv
// Byte-wide single-port RAM bank with registered, read-first read port.
// Define BYTE_MEM_CLEAR_ON_RESET_EN to zero the whole array with a sweep after every reset.
module byte_mem #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  byte_mem_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Single write port shared between user writes and the clear sweep.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;

`ifdef BYTE_MEM_CLEAR_ON_RESET_EN
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic [ADDR_W-1:0] clr_addr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    busy          = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = bus.addr;
    mem_wdata     = bus.wdata;
    case (state_reg)
      ST_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_addr_reg;
        mem_wdata = '0;
        if (clr_addr_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
        end else begin
          clr_addr_next = clr_addr_reg + 1'b1;
        end
      end
      default: begin
        mem_we = bus.wen;
      end
    endcase
    // A reset edge restarts the sweep, so nothing is written on it.
    if (rst) begin
      mem_we = 1'b0;
    end
  end
`else
  always_comb begin
    busy      = 1'b0;
    mem_we    = bus.wen & ~rst;
    mem_waddr = bus.addr;
    mem_wdata = bus.wdata;
  end
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_reg[mem_waddr] <= mem_wdata;
    end
  end

  // Read samples the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst || busy) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= mem_reg[bus.addr];
    end
  end

  assign bus.rdata = rdata_reg;
  assign bus.busy  = busy;
endmodule

// File: tb/tb_byte_mem.sv
// Bench for byte_mem: directed vectors, a per-cycle array model, and literal spot checks.
module tb_byte_mem;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
`ifdef BYTE_MEM_CLEAR_ON_RESET_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  byte_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  byte_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: expected array contents (with known flags) and sweep cycles remaining.
  logic [7:0] mdl [DEPTH];
  bit         mdl_known [DEPTH];
  logic [7:0] exp_rdata;
  bit         exp_known;
  int         busy_left;
  bit         started = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  initial begin
    busy_left = 0;
    exp_known = 1'b0;
    exp_rdata = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]       = 8'h00;
      mdl_known[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      if (rst) begin
        started   = 1'b1;
        exp_rdata = 8'h00;
        exp_known = 1'b1;
        if (SWEEP) begin
          busy_left = DEPTH;
          for (int i = 0; i < DEPTH; i++) begin
            mdl[i]       = 8'h00;
            mdl_known[i] = 1'b1;
          end
        end
      end else if (busy_left > 0) begin
        busy_left--;
        exp_rdata = 8'h00;
        exp_known = 1'b1;
      end else begin
        exp_rdata = mdl[bus.addr];
        exp_known = mdl_known[bus.addr];
        if (bus.wen) begin
          mdl[bus.addr]       = bus.wdata;
          mdl_known[bus.addr] = 1'b1;
        end
      end
      @(negedge clk);
      if (started) begin
        check("busy_cycle", {31'd0, bus.busy}, {31'd0, (busy_left > 0)});
        if (exp_known) begin
          check("rdata_cycle", {24'd0, bus.rdata}, {24'd0, exp_rdata});
        end
      end
    end
  end

  task automatic step(input bit r, input bit w, input int a, input logic [7:0] d);
    logic [31:0] av;
    av        = a;
    rst       = r;
    bus.wen   = w;
    bus.addr  = av[5:0];
    bus.wdata = d;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops; an expired bound is a failure.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      step(1'b0, 1'b0, 0, 8'h00);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout got busy=%b want 0 at %0t", bus.busy, $time);
    end
  endtask

  task automatic read_lit(input string name, input int a, input logic [7:0] want);
    step(1'b0, 1'b0, a, 8'h00);
    check(name, {24'd0, bus.rdata}, {24'd0, want});
  endtask

  int n;

  initial begin
    bus.wen   = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    step(1'b0, 1'b0, 0, 8'h00);

    // Reset, then a dropped write during the sweep.
    step(1'b1, 1'b0, 0, 8'h00);
    check("rst_rdata", {24'd0, bus.rdata}, 32'h0);
    check("rst_busy", {31'd0, bus.busy}, {31'd0, SWEEP});
    step(1'b0, 1'b1, 3, 8'hFF);
    count_busy(n);
    check("busy_len", n + 1, SWEEP ? 64 : 1);
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, a, 8'h00);
    read_lit("busy_write_dropped", 3, SWEEP ? 8'h00 : 8'hFF);

    // Basic write/read, including the top address.
    step(1'b0, 1'b1, 5, 8'hA5);
    step(1'b0, 1'b1, 63, 8'h3C);
    read_lit("read_5", 5, 8'hA5);
    read_lit("read_63", 63, 8'h3C);

    // Read-first collision.
    step(1'b0, 1'b1, 10, 8'h11);
    step(1'b0, 1'b1, 10, 8'h22);
    check("collision_old", {24'd0, bus.rdata}, 32'h11);
    read_lit("collision_new", 10, 8'h22);

    // Fill the array with a pattern and read it back.
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b1, a, 8'((a * 7 + 3) & 8'hFF));
    for (int a = DEPTH - 1; a >= 0; a--) step(1'b0, 1'b0, a, 8'h00);
    read_lit("pattern_5", 5, 8'h26);

    // Reset with a write attempt held during it.
    step(1'b0, 1'b1, 9, 8'h77);
    step(1'b1, 1'b1, 9, 8'hEE);
    check("rst2_rdata", {24'd0, bus.rdata}, 32'h0);
    step(1'b1, 1'b1, 9, 8'hEE);
    check("rst2_rdata_hold", {24'd0, bus.rdata}, 32'h0);
    check("rst2_busy", {31'd0, bus.busy}, {31'd0, SWEEP});
    rst = 1'b0;
    bus.wen = 1'b0;
    count_busy(n);
    check("busy_len2", n, SWEEP ? 64 : 0);
    read_lit("keep_9", 9, SWEEP ? 8'h00 : 8'h77);

    // Reset reasserted mid-sweep.
    step(1'b0, 1'b1, 20, 8'h5A);
    step(1'b1, 1'b0, 0, 8'h00);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 0, 8'h00);
    check("mid_busy", {31'd0, bus.busy}, {31'd0, SWEEP});
    step(1'b1, 1'b0, 0, 8'h00);
    count_busy(n);
    check("busy_len3", n, SWEEP ? 64 : 0);
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, a, 8'h00);
    read_lit("mid_20", 20, SWEEP ? 8'h00 : 8'h5A);

    step(1'b0, 1'b0, 0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
